// File: rtl/stream_pattern_match.sv
// stream_pattern_match
//
// Serial bit-stream pattern detector. Incoming bits shift into a PAT_W-bit
// window; once the window holds PAT_W valid bits, it is compared against a
// programmable pattern under a per-bit compare mask. A hit produces a
// one-cycle match pulse one clock later, records the stream index of the
// bit that completed the match, and bumps a saturating match counter.
//
// Ports
//   clk          in   1      clock, all state updates on the rising edge
//   rst_n        in   1      synchronous active-low reset
//   cfg_we       in   1      load cfg_pat/cfg_mask/cfg_overlap, clear stream state
//   cfg_pat      in   PAT_W  pattern, bit PAT_W-1 is the first-received bit
//   cfg_mask     in   PAT_W  per-bit compare enable (1 = compared, 0 = don't-care)
//   cfg_overlap  in   1      1 = overlapping matches, 0 = non-overlapping
//   clr          in   1      clear window, fill, position and match counters
//   in_valid     in   1      in_bit is accepted on this cycle
//   in_bit       in   1      serial stream bit
//   match        out  1      one-cycle pulse, the cycle after a hit
//   match_pos    out  POS_W  stream index of the last bit of the latest match
//   match_cnt    out  CNT_W  saturating match count
//   cnt_sat      out  1      sticky, set once match_cnt has saturated
//   armed        out  1      window holds PAT_W valid bits
//
// State table
//   state       | meaning
//   ST_EMPTY    | no valid bits in the window (fcnt = 0)
//   ST_FILLING  | window partially filled (0 < fcnt < PAT_W)
//   ST_ARMED    | window full, every accepted bit is a compare (fcnt = PAT_W)

module stream_pattern_match #(
    parameter int PAT_W = 4,
    parameter int POS_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pat,
    input  logic [PAT_W-1:0] cfg_mask,
    input  logic             cfg_overlap,
    input  logic             clr,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             match,
    output logic [POS_W-1:0] match_pos,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat,
    output logic             armed
);

    localparam int FCNT_W = $clog2(PAT_W + 1);
    localparam logic [FCNT_W-1:0] FCNT_FULL = FCNT_W'(PAT_W);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_ARMED   = 2'd2
    } state_t;

    state_t             state,     state_nx;
    logic [PAT_W-1:0]   pat,       pat_nx;
    logic [PAT_W-1:0]   mask,      mask_nx;
    logic               overlap,   overlap_nx;
    logic [PAT_W-1:0]   win,       win_nx;
    logic [FCNT_W-1:0]  fcnt,      fcnt_nx;
    logic [POS_W-1:0]   pos,       pos_nx;
    logic               match_nx;
    logic [POS_W-1:0]   match_pos_nx;
    logic [CNT_W-1:0]   match_cnt_nx;
    logic               cnt_sat_nx;

    logic               accept;
    logic [PAT_W-1:0]   win_shift;
    logic [FCNT_W-1:0]  fcnt_inc;
    logic               hit;

    // Configuration and clear both take precedence over a presented bit,
    // so the bit on such a cycle never enters the window.
    always_comb begin
        accept    = in_valid & ~cfg_we & ~clr;
        win_shift = {win[PAT_W-2:0], in_bit};
        fcnt_inc  = (fcnt == FCNT_FULL) ? FCNT_FULL : fcnt + FCNT_W'(1);
        hit       = accept && (fcnt_inc == FCNT_FULL) &&
                    (((win_shift ^ pat) & mask) == '0);
    end

    always_comb begin
        state_nx     = state;
        pat_nx       = pat;
        mask_nx      = mask;
        overlap_nx   = overlap;
        win_nx       = win;
        fcnt_nx      = fcnt;
        pos_nx       = pos;
        match_nx     = 1'b0;
        match_pos_nx = match_pos;
        match_cnt_nx = match_cnt;
        cnt_sat_nx   = cnt_sat;

        if (cfg_we || clr) begin
            if (cfg_we) begin
                pat_nx     = cfg_pat;
                mask_nx    = cfg_mask;
                overlap_nx = cfg_overlap;
            end
            state_nx     = ST_EMPTY;
            win_nx       = '0;
            fcnt_nx      = '0;
            pos_nx       = '0;
            match_cnt_nx = '0;
            cnt_sat_nx   = 1'b0;
        end else if (accept) begin
            win_nx  = win_shift;
            fcnt_nx = fcnt_inc;
            pos_nx  = pos + POS_W'(1);

            case (state)
                ST_EMPTY,
                ST_FILLING: state_nx = (fcnt_inc == FCNT_FULL) ? ST_ARMED : ST_FILLING;
                ST_ARMED:   state_nx = ST_ARMED;
                default:    state_nx = ST_EMPTY;
            endcase

            if (hit) begin
                match_nx     = 1'b1;
                match_pos_nx = pos;
                if (&match_cnt) begin
                    cnt_sat_nx = 1'b1;
                end else begin
                    match_cnt_nx = match_cnt + CNT_W'(1);
                end
                // Non-overlapping mode: the next match must be built from
                // PAT_W fresh bits, so the fill count restarts.
                if (!overlap) begin
                    fcnt_nx  = '0;
                    state_nx = ST_EMPTY;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_EMPTY;
            pat       <= '0;
            mask      <= '1;
            overlap   <= 1'b1;
            win       <= '0;
            fcnt      <= '0;
            pos       <= '0;
            match     <= 1'b0;
            match_pos <= '0;
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
        end else begin
            state     <= state_nx;
            pat       <= pat_nx;
            mask      <= mask_nx;
            overlap   <= overlap_nx;
            win       <= win_nx;
            fcnt      <= fcnt_nx;
            pos       <= pos_nx;
            match     <= match_nx;
            match_pos <= match_pos_nx;
            match_cnt <= match_cnt_nx;
            cnt_sat   <= cnt_sat_nx;
        end
    end

    assign armed = (state == ST_ARMED);

endmodule

// File: tb/tb_stream_pattern_match.sv
// Testbench for stream_pattern_match: a table of per-cycle input/expected
// records for the default configuration (PAT_W=4, CNT_W=8), plus a
// hand-written saturation sequence on a CNT_W=2 instance.

module tb_stream_pattern_match;

    logic       clk;
    logic       rst_n;
    logic       cfg_we;
    logic [3:0] cfg_pat;
    logic [3:0] cfg_mask;
    logic       cfg_overlap;
    logic       clr;
    logic       in_valid;
    logic       in_bit;

    logic       match;
    logic [7:0] match_pos;
    logic [7:0] match_cnt;
    logic       cnt_sat;
    logic       armed;

    logic       s_match;
    logic [7:0] s_match_pos;
    logic [1:0] s_match_cnt;
    logic       s_cnt_sat;
    logic       s_armed;

    int total;
    int passed;

    stream_pattern_match dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_pat     (cfg_pat),
        .cfg_mask    (cfg_mask),
        .cfg_overlap (cfg_overlap),
        .clr         (clr),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .match       (match),
        .match_pos   (match_pos),
        .match_cnt   (match_cnt),
        .cnt_sat     (cnt_sat),
        .armed       (armed)
    );

    stream_pattern_match #(.PAT_W(4), .POS_W(8), .CNT_W(2)) dut_s (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_pat     (cfg_pat),
        .cfg_mask    (cfg_mask),
        .cfg_overlap (cfg_overlap),
        .clr         (clr),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .match       (s_match),
        .match_pos   (s_match_pos),
        .match_cnt   (s_match_cnt),
        .cnt_sat     (s_cnt_sat),
        .armed       (s_armed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       cw;
        logic [3:0] p;
        logic [3:0] m;
        logic       o;
        logic       c;
        logic       v;
        logic       b;
        logic       em;
        logic [7:0] ep;
        logic [7:0] ec;
        logic       es;
        logic       ea;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic cw,
                                input logic [3:0] p, input logic [3:0] m,
                                input logic o, input logic c,
                                input logic v, input logic b,
                                input logic em, input logic [7:0] ep,
                                input logic [7:0] ec, input logic es,
                                input logic ea);
        vec_t t;
        t.r = r;  t.cw = cw; t.p = p;  t.m = m;  t.o = o; t.c = c;
        t.v = v;  t.b = b;   t.em = em; t.ep = ep; t.ec = ec;
        t.es = es; t.ea = ea;
        vecs.push_back(t);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        rst_n = 1'b0; cfg_we = 1'b0; cfg_pat = '0; cfg_mask = '0;
        cfg_overlap = 1'b0; clr = 1'b0; in_valid = 1'b0; in_bit = 1'b0;

        //   r  cw pat      mask     o  c  v  b    m  pos cnt s  a
        // reset
        add(0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0,   0, 0,  0,  0, 0);
        // overlap mode, stream 1,0,1,1,0,1,1
        add(1, 1, 4'b1011, 4'b1111, 1, 0, 0, 0,   0, 0,  0,  0, 0);
        add(1, 0, 4'b0000, 4'b0000, 0, 0, 1, 1,   0, 0,  0,  0, 0);
        add(1, 0, 4'b0000, 4'b0000, 0, 0, 1, 0,   0, 0,  0,  0, 0);
        add(1, 0, 4'b0000, 4'b0000, 0, 0, 1, 1,   0, 0,  0,  0, 0);
        add(1, 0, 4'b0000, 4'b0000, 0, 0, 1, 1,   1, 3,  1,  0, 1);
        add(1, 0, 4'b0000, 4'b0000, 0, 0, 1, 0,   0, 3,  1,  0, 1);
        add(1, 0, 4'b0000, 4'b0000, 0, 0, 1, 1,   0, 3,  1,  0, 1);
        add(1, 0, 4'b0000, 4'b0000, 0, 0, 1, 1,   1, 6,  2,  0, 1);
        add(1, 0, 4'b0000, 4'b0000, 0, 0, 0, 1,   0, 6,  2,  0, 1);
        // non-overlap mode, same stream
        add(1, 1, 4'b1011, 4'b1111, 0, 0, 0, 0,   0, 6,  0,  0, 0);
        add(1, 0, 4'b0000, 4'b0000, 0, 0, 1, 1,   0, 6,  0,  0, 0);
        add(1, 0, 4'b0000, 4'b0000, 0, 0, 1, 0,   0, 6,  0,  0, 0);
        add(1, 0, 4'b0000, 4'b0000, 0, 0, 1, 1,   0, 6,  0,  0, 0);
        add(1, 0, 4'b0000, 4'b0000, 0, 0, 1, 1,   1, 3,  1,  0, 0);
        add(1, 0, 4'b0000, 4'b0000, 0, 0, 1, 0,   0, 3,  1,  0, 0);
        add(1, 0, 4'b0000, 4'b0000, 0, 0, 1, 1,   0, 3,  1,  0, 0);
        add(1, 0, 4'b0000, 4'b0000, 0, 0, 1, 1,   0, 3,  1,  0, 0);
        // mask 1001/1001: 1,1,1,1 hits; after clr 0,1,1,1 does not
        add(1, 1, 4'b1001, 4'b1001, 1, 0, 0, 0,   0, 3,  0,  0, 0);
        add(1, 0, 4'b0000, 4'b0000, 0, 0, 1, 1,   0, 3,  0,  0, 0);
        add(1, 0, 4'b0000, 4'b0000, 0, 0, 1, 1,   0, 3,  0,  0, 0);
        add(1, 0, 4'b0000, 4'b0000, 0, 0, 1, 1,   0, 3,  0,  0, 0);
        add(1, 0, 4'b0000, 4'b0000, 0, 0, 1, 1,   1, 3,  1,  0, 1);
        add(1, 0, 4'b0000, 4'b0000, 0, 1, 0, 0,   0, 3,  0,  0, 0);
        add(1, 0, 4'b0000, 4'b0000, 0, 0, 1, 0,   0, 3,  0,  0, 0);
        add(1, 0, 4'b0000, 4'b0000, 0, 0, 1, 1,   0, 3,  0,  0, 0);
        add(1, 0, 4'b0000, 4'b0000, 0, 0, 1, 1,   0, 3,  0,  0, 0);
        add(1, 0, 4'b0000, 4'b0000, 0, 0, 1, 1,   0, 3,  0,  0, 1);
        add(1, 0, 4'b0000, 4'b0000, 0, 0, 1, 1,   1, 4,  1,  0, 1);
        // clr with a bit present: bit discarded
        add(1, 0, 4'b0000, 4'b0000, 0, 1, 1, 1,   0, 4,  0,  0, 0);
        // cfg_we + clr + bit: cfg wins, bit discarded, mask all zeros
        add(1, 1, 4'b0000, 4'b0000, 1, 1, 1, 1,   0, 4,  0,  0, 0);
        add(1, 0, 4'b0000, 4'b0000, 0, 0, 1, 0,   0, 4,  0,  0, 0);
        add(1, 0, 4'b0000, 4'b0000, 0, 0, 1, 1,   0, 4,  0,  0, 0);
        add(1, 0, 4'b0000, 4'b0000, 0, 0, 1, 0,   0, 4,  0,  0, 0);
        add(1, 0, 4'b0000, 4'b0000, 0, 0, 1, 0,   1, 3,  1,  0, 1);
        add(1, 0, 4'b0000, 4'b0000, 0, 0, 1, 1,   1, 4,  2,  0, 1);
        add(1, 0, 4'b0000, 4'b0000, 0, 0, 0, 1,   0, 4,  2,  0, 1);
        add(1, 0, 4'b0000, 4'b0000, 0, 0, 1, 0,   1, 5,  3,  0, 1);
        // reset mid-stream while the completing bit is presented
        add(1, 1, 4'b1011, 4'b1111, 1, 0, 0, 0,   0, 5,  0,  0, 0);
        add(1, 0, 4'b0000, 4'b0000, 0, 0, 1, 1,   0, 5,  0,  0, 0);
        add(1, 0, 4'b0000, 4'b0000, 0, 0, 1, 0,   0, 5,  0,  0, 0);
        add(1, 0, 4'b0000, 4'b0000, 0, 0, 1, 1,   0, 5,  0,  0, 0);
        add(0, 0, 4'b0000, 4'b0000, 0, 0, 1, 1,   0, 0,  0,  0, 0);
        // after reset: pat=0000, mask=1111, overlap=1
        add(1, 0, 4'b0000, 4'b0000, 0, 0, 1, 0,   0, 0,  0,  0, 0);
        add(1, 0, 4'b0000, 4'b0000, 0, 0, 1, 0,   0, 0,  0,  0, 0);
        add(1, 0, 4'b0000, 4'b0000, 0, 0, 1, 0,   0, 0,  0,  0, 0);
        add(1, 0, 4'b0000, 4'b0000, 0, 0, 1, 0,   1, 3,  1,  0, 1);
        add(1, 0, 4'b0000, 4'b0000, 0, 0, 1, 1,   0, 3,  1,  0, 1);
        add(1, 0, 4'b0000, 4'b0000, 0, 0, 1, 0,   0, 3,  1,  0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n       = vecs[i].r;
            cfg_we      = vecs[i].cw;
            cfg_pat     = vecs[i].p;
            cfg_mask    = vecs[i].m;
            cfg_overlap = vecs[i].o;
            clr         = vecs[i].c;
            in_valid    = vecs[i].v;
            in_bit      = vecs[i].b;
            tick();
            chk($sformatf("v%0d.match", i),     32'(match),     32'(vecs[i].em));
            chk($sformatf("v%0d.match_pos", i), 32'(match_pos), 32'(vecs[i].ep));
            chk($sformatf("v%0d.match_cnt", i), 32'(match_cnt), 32'(vecs[i].ec));
            chk($sformatf("v%0d.cnt_sat", i),   32'(cnt_sat),   32'(vecs[i].es));
            chk($sformatf("v%0d.armed", i),     32'(armed),     32'(vecs[i].ea));
        end

        // Saturation on the CNT_W=2 instance: mask 0000, eight ones.
        rst_n = 1'b1; clr = 1'b0;
        cfg_we = 1'b1; cfg_pat = 4'b0000; cfg_mask = 4'b0000; cfg_overlap = 1'b1;
        in_valid = 1'b0; in_bit = 1'b0;
        tick();
        chk("sat.cfg.cnt", 32'(s_match_cnt), 32'd0);
        chk("sat.cfg.sat", 32'(s_cnt_sat),   32'd0);
        cfg_we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            int exp_cnt;
            in_valid = 1'b1; in_bit = 1'b1;
            tick();
            exp_cnt = (i < 3) ? 0 : ((i - 2 > 3) ? 3 : i - 2);
            chk($sformatf("sat.b%0d.match", i), 32'(s_match),     (i >= 3) ? 32'd1 : 32'd0);
            chk($sformatf("sat.b%0d.cnt", i),   32'(s_match_cnt), 32'(exp_cnt));
            chk($sformatf("sat.b%0d.sat", i),   32'(s_cnt_sat),   (i >= 6) ? 32'd1 : 32'd0);
            if (i >= 3)
                chk($sformatf("sat.b%0d.pos", i), 32'(s_match_pos), 32'(i));
        end
        in_valid = 1'b0;
        tick();
        chk("sat.idle.match", 32'(s_match),     32'd0);
        chk("sat.idle.sat",   32'(s_cnt_sat),   32'd1);
        chk("sat.idle.cnt",   32'(s_match_cnt), 32'd3);
        clr = 1'b1;
        tick();
        chk("sat.clr.sat",   32'(s_cnt_sat),   32'd0);
        chk("sat.clr.cnt",   32'(s_match_cnt), 32'd0);
        chk("sat.clr.armed", 32'(s_armed),     32'd0);
        clr = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/stream_pattern_match.md
STREAM_PATTERN_MATCH -- requirements
Module: stream_pattern_match

Interface
REQ-001 The block SHALL have the parameter PAT_W, default 4, giving the pattern length in bits (range 2..32).
REQ-002 The block SHALL have the parameter POS_W, default 8, giving the width of the stream bit-position counter.
REQ-003 The block SHALL have the parameter CNT_W, default 8, giving the width of the match counter.
REQ-004 The block SHALL have one clock and a synchronous, active-low reset, named clk and rst_n.
REQ-005 clk  in  1  clock; all state SHALL update on its rising edge.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 cfg_we  in  1  configuration load strobe.
REQ-008 cfg_pat  in  PAT_W  pattern; bit PAT_W-1 is the first-received bit of the pattern.
REQ-009 cfg_mask  in  PAT_W  per-bit compare enable; a bit set to 1 means compared, 0 means don't-care.
REQ-010 cfg_overlap  in  1  selects the mode: 1 = overlapping matches, 0 = non-overlapping.
REQ-011 clr  in  1  clears the position counter, match counter and window; configuration is kept.
REQ-012 in_valid  in  1  in_bit is accepted on a cycle where this is high.
REQ-013 in_bit  in  1  serial stream bit.
REQ-014 match  out  1  one-cycle pulse on a detected match.
REQ-015 match_pos  out  POS_W  index of the last bit of the most recent matching window.
REQ-016 match_cnt  out  CNT_W  number of matches since reset/clr/cfg, saturating.
REQ-017 cnt_sat  out  1  sticky flag, set when match_cnt has saturated.
REQ-018 armed  out  1  high when the window holds at least PAT_W valid bits.

Function
REQ-019 Window register win[PAT_W-1:0] SHALL shift left on each accepted bit, with in_bit entering win[0].
REQ-020 Fill counter fcnt (0..PAT_W) SHALL increment on each accepted bit and saturate at PAT_W.
REQ-021 State SHALL be one of EMPTY (fcnt=0), FILLING (0<fcnt<PAT_W) or ARMED (fcnt=PAT_W).
- EMPTY->FILLING on the first accepted bit.
- FILLING->ARMED on the bit that brings fcnt to PAT_W.
- ARMED->EMPTY on a non-overlap match, clr or cfg_we.
REQ-022 A hit SHALL occur on an accepted bit when the post-shift fcnt equals PAT_W and ((win_next ^ pat) & mask) == 0.
REQ-023 On a hit, match SHALL be asserted on the following cycle for exactly one cycle (latency 1), and SHALL never be high two cycles in a row without two accepted bits.
REQ-024 On a hit, match_pos SHALL load the index of the accepted bit on the same edge as match; otherwise it SHALL hold.
REQ-025 The position counter SHALL start at 0, increment per accepted bit, and wrap from 2^POS_W-1 to 0.
REQ-026 In overlap mode, fcnt SHALL stay at PAT_W after a hit, so consecutive windows can match.
REQ-027 In non-overlap mode, fcnt SHALL clear to 0 on a hit, so the next match needs PAT_W fresh bits.
REQ-028 match_cnt SHALL increment per hit and saturate at all-ones; cnt_sat SHALL set on the hit that finds match_cnt already all-ones and SHALL stay set until clr, cfg_we or reset.
REQ-029 A mask of all zeros SHALL produce a hit on every accepted bit while ARMED.
REQ-030 cfg_we SHALL load pat, mask and overlap, and clear win, fcnt, the position counter, match_cnt and cnt_sat; any bit presented on the same cycle SHALL be discarded.
REQ-031 clr SHALL clear win, fcnt, the position counter, match_cnt and cnt_sat; a bit presented on the same cycle SHALL be discarded; cfg_we SHALL win over clr.
REQ-032 Cycles with in_valid low SHALL change no state, and match SHALL be 0 on those cycles.
REQ-033 Configuration inputs SHALL be sampled only on cfg_we cycles.

Reset
REQ-034 While rst_n is low at a clock edge, the block SHALL set pat=0, mask=all ones, overlap=1, win=0, fcnt=0, the position counter to 0, match=0, match_pos=0, match_cnt=0, cnt_sat=0 and armed=0.
REQ-035 Reset SHALL take priority over cfg_we, clr and in_valid, including reset asserted mid-stream; all in-flight bits and a pending match pulse SHALL be dropped.

Verification (PAT_W=4 unless stated)
REQ-036 Overlap mode: cfg pat=1011, mask=1111, overlap=1; stream 1,0,1,1,0,1,1 with in_valid high continuously -> match pulses for bits 3 and 6, match_pos=3 then 6, match_cnt=2.
REQ-037 Non-overlap mode: same stream with overlap=0 -> a single match at pos 3, match_cnt=1, armed=0 after the match.
REQ-038 Mask: pat=1001, mask=1001; stream 1,1,1,1 -> match at pos 3; stream 0,1,1,1 (after clr) -> no match.
REQ-039 Saturation: CNT_W=2, mask=0000, stream of 8 ones -> match_cnt stops at 3; cnt_sat goes to 1 on the 4th hit, at the bit at pos 6.
REQ-040 Reset and priority: rst_n pulled low after 3 bits -> armed=0 and counters 0, with no match pulse from those bits; cfg_we presented together with in_valid -> that bit is discarded and the position counter is 0.
